// File: rtl/bcd_pkg.sv
// Shared BCD digit definitions and helpers used by the BCD counter family.
package bcd_pkg;
    localparam int unsigned BCD_W   = 4;
    localparam logic [3:0]  BCD_MAX = 4'd9;

    typedef logic [BCD_W-1:0] bcd_digit_t;

    // Force any non-decimal nibble to the largest legal digit.
    function automatic bcd_digit_t bcd_clamp(input bcd_digit_t d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction
endpackage

// File: rtl/bcd_digit_dec.sv
// Single BCD digit decrementer: steps down on borrow_in, 0 rolls to 9 and borrows onward.
module bcd_digit_dec
    import bcd_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       borrow_in,
    output logic [3:0] digit_next,
    output logic       borrow_out
);
    always_comb begin
        digit_next = digit;
        if (borrow_in) begin
            digit_next = (digit == 4'd0) ? BCD_MAX : digit - 4'd1;
        end
    end

    assign borrow_out = borrow_in & (digit == 4'd0);
endmodule

// File: rtl/bcd_down_counter.sv
// Loadable multi-digit BCD down-counter with per-digit borrow enables, zero flag
// and a registered terminal-count pulse.
module bcd_down_counter
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = 4,
    parameter bit          WRAP   = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   din,
    input  logic                  en,
    output logic [4*DIGITS-1:0]   q,
    output logic [DIGITS-1:1]     brw,
    output logic                  zero,
    output logic                  tc
);
    logic [4*DIGITS-1:0] count_q, count_d;
    logic [4*DIGITS-1:0] dec_val, load_val;
    logic [DIGITS:0]     borrow;
    logic                tc_q, tc_d;
    logic                hold_at_zero, dec_en;

    assign zero         = (count_q == '0);
    assign hold_at_zero = (WRAP == 1'b0) && zero;
    assign dec_en       = en & ~load & ~reset & ~hold_at_zero;
    assign borrow[0]    = dec_en;

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        bcd_digit_dec u_dec (
            .digit      (count_q[4*k +: 4]),
            .borrow_in  (borrow[k]),
            .digit_next (dec_val[4*k +: 4]),
            .borrow_out (borrow[k+1])
        );
        assign load_val[4*k +: 4] = bcd_clamp(din[4*k +: 4]);
    end

    assign brw = borrow[DIGITS-1:1];

    // A borrow out of the top digit means 0...0 was decremented: the digit chain
    // already yields all nines, which is the wrap result; non-wrapping holds zero.
    always_comb begin
        count_d = dec_val;
        if (borrow[DIGITS] && !WRAP) begin
            count_d = '0;
        end
        tc_d = dec_en & ~zero & (count_d == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            tc_q    <= 1'b0;
        end else if (load) begin
            count_q <= load_val;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    assign q  = count_q;
    assign tc = tc_q;
endmodule
